// File: rtl/fbank_coef_seq.sv
// fbank_coef_seq: NUM_BANKS mel-filterbank coefficient RAMs with a burst read streamer.
// Optional FBANK_PARITY_EN: per-entry even parity and a sticky par_err output.
module fbank_coef_seq #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 17,
    parameter int NUM_BANKS  = 2,
    parameter int OUTPUT_REG = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_wr_en,
    input  logic [2:0]                      cfg_bank,
    input  logic [ADDR_WIDTH-1:0]           cfg_addr,
    input  logic [DATA_WIDTH-1:0]           cfg_data,
    output logic                            cfg_drop,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [ADDR_WIDTH:0]             burst_len,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] coef_data,
    output logic                            coef_valid,
    input  logic                            coef_ready,
    output logic                            coef_last,
    output logic                            busy,
    output logic                            done
`ifdef FBANK_PARITY_EN
    ,
    output logic                            par_err
`endif
);

`ifdef FBANK_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int EW        = DATA_WIDTH + PW;
    localparam int VW        = NUM_BANKS * EW;
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    // One slot per pipeline stage between issue and output keeps full rate.
    localparam int BUF_DEPTH = 2 + OUTPUT_REG;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam logic [3:0]          NB_L    = 4'(NUM_BANKS);
    localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic idle;
    logic start_acc;
    logic start_ok;
    logic start_zero;
    logic issue;
    logic issue_last;
    logic credit_ok;
    logic pop;
    logic head_last;
    logic done_d, done_q;
    logic wr_ok;
    logic drop_d, drop_q;

    logic [EW-1:0] wdata;
    logic [VW-1:0] rd_vec;

    logic          rd_v_q;
    logic          rd_last_q;
    logic          push_v;
    logic          push_last;
    logic [VW-1:0] push_data;
    logic [1:0]    inflight;
    logic [2:0]    occ;

    logic [VW-1:0]        buf_data_q [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] buf_last_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [VW-1:0]        head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign idle       = (state_q == S_IDLE);
    assign start_acc  = idle && start;
    assign start_ok   = start_acc && (burst_len != '0);
    assign start_zero = start_acc && (burst_len == '0);
    assign busy       = !idle;

    assign wr_ok  = cfg_wr_en && idle && ({1'b0, cfg_bank} < NB_L);
    assign drop_d = cfg_wr_en && !wr_ok;

`ifdef FBANK_PARITY_EN
    assign wdata = {^cfg_data, cfg_data};
`else
    assign wdata = cfg_data;
`endif

    // First read goes out in the start cycle itself, later ones from addr_q.
    assign rd_addr = idle ? base_addr : addr_q;

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic [EW-1:0] mem [DEPTH];
        logic [EW-1:0] rd_q;
        logic          wr_hit;

        assign wr_hit = wr_ok && (cfg_bank == 3'(k));

        // Bank RAM; same-cycle write is forwarded so a start sees the new value.
        always_ff @(posedge clk) begin
            if (wr_hit) begin
                mem[cfg_addr] <= wdata;
            end
            if (issue) begin
                rd_q <= (wr_hit && (cfg_addr == rd_addr)) ? wdata : mem[rd_addr];
            end
        end

        assign rd_vec[k*EW +: EW] = rd_q;
    end

    // Read-stage valid/last tags travel alongside the RAM output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v_q    <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            rd_v_q    <= issue;
            rd_last_q <= issue_last;
        end
    end

    if (OUTPUT_REG != 0) begin : g_oreg
        logic          s2_v_q;
        logic          s2_last_q;
        logic [VW-1:0] s2_data_q;

        // Extra register stage after the RAM for timing.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_v_q    <= 1'b0;
                s2_last_q <= 1'b0;
                s2_data_q <= '0;
            end else begin
                s2_v_q    <= rd_v_q;
                s2_last_q <= rd_last_q;
                s2_data_q <= rd_vec;
            end
        end

        assign push_v    = s2_v_q;
        assign push_last = s2_last_q;
        assign push_data = s2_data_q;
        assign inflight  = {1'b0, rd_v_q} + {1'b0, s2_v_q};
    end else begin : g_noreg
        assign push_v    = rd_v_q;
        assign push_last = rd_last_q;
        assign push_data = rd_vec;
        assign inflight  = {1'b0, rd_v_q};
    end

    assign coef_valid = (cnt_q != '0);
    assign pop        = coef_valid && coef_ready;
    assign head_data  = buf_data_q[rd_ptr_q];
    assign head_last  = buf_last_q[rd_ptr_q];

    // A beat leaving this cycle frees its slot for a read issued this cycle.
    assign occ       = 3'(cnt_q) + 3'(inflight);
    assign credit_ok = (occ - 3'(pop)) < 3'(BUF_DEPTH);

    // Output buffer: absorbs in-flight reads while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data_q[i] <= '0;
            end
            buf_last_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            if (push_v) begin
                buf_data_q[wr_ptr_q] <= push_data;
                buf_last_q[wr_ptr_q] <= push_last;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            cnt_q <= cnt_q + CNT_W'(push_v) - CNT_W'(pop);
        end
    end

    // Strip parity and hold the bus at zero when nothing is offered.
    always_comb begin
        coef_data = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            coef_data[k*DATA_WIDTH +: DATA_WIDTH] =
                coef_valid ? head_data[k*EW +: DATA_WIDTH] : '0;
        end
    end

    assign coef_last = coef_valid && head_last;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (burst_len == LEN_ONE) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (rem_q == LEN_ONE)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: read issue, last tag and completion pulse.
    always_comb begin
        issue      = 1'b0;
        issue_last = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                issue      = start_ok;
                issue_last = start_ok && (burst_len == LEN_ONE);
                done_d     = start_zero;
            end
            S_RUN: begin
                issue      = credit_ok;
                issue_last = credit_ok && (rem_q == LEN_ONE);
            end
            S_DRAIN: begin
                done_d = pop && head_last;
            end
            default: begin
                issue = 1'b0;
            end
        endcase
    end

    // Burst address and remaining-read counter next state.
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (start_ok) begin
            addr_d = base_addr + ADDR_WIDTH'(1);
            rem_d  = burst_len - LEN_ONE;
        end else if (issue) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            rem_d  = rem_q - LEN_ONE;
        end
    end

    // Sequencer and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            done_q <= done_d;
            drop_q <= drop_d;
        end
    end

    assign done     = done_q;
    assign cfg_drop = drop_q;

`ifdef FBANK_PARITY_EN
    logic par_hit;
    logic par_q;

    // Any bank with odd parity in the head beat flags an error.
    always_comb begin
        par_hit = 1'b0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            par_hit = par_hit | (^head_data[k*EW +: EW]);
        end
    end

    // Sticky error, cleared when a new start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (start_acc) begin
            par_q <= 1'b0;
        end else if (pop && par_hit) begin
            par_q <= 1'b1;
        end
    end

    assign par_err = par_q;
`endif

endmodule

// File: tb/tb_fbank_coef_seq.sv
// tb_fbank_coef_seq: directed bench for fbank_coef_seq (default parameters).
// Expected beats come from a bench-side copy of the coefficient RAM.
module tb_fbank_coef_seq;

    localparam int AW = 10;
    localparam int DW = 17;
    localparam int NB = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_wr_en = 1'b0;
    logic [2:0]        cfg_bank = '0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [DW-1:0]     cfg_data = '0;
    logic              cfg_drop;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       burst_len = '0;
    logic [NB*DW-1:0]  coef_data;
    logic              coef_valid;
    logic              coef_ready = 1'b0;
    logic              coef_last;
    logic              busy;
    logic              done;
`ifdef FBANK_PARITY_EN
    logic              par_err;
`endif

    int total = 0;
    int bad = 0;
    logic [DW-1:0] model [NB][1024];

    fbank_coef_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_wr_en  (cfg_wr_en),
        .cfg_bank   (cfg_bank),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_drop   (cfg_drop),
        .start      (start),
        .base_addr  (base_addr),
        .burst_len  (burst_len),
        .coef_data  (coef_data),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_last  (coef_last),
        .busy       (busy),
        .done       (done)
`ifdef FBANK_PARITY_EN
        ,
        .par_err    (par_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB*DW-1:0] expv(input int a);
        return {model[1][a], model[0][a]};
    endfunction

    task automatic wr(input int bank, input int addr, input logic [DW-1:0] d);
        @(negedge clk);
        cfg_wr_en = 1'b1;
        cfg_bank  = 3'(bank);
        cfg_addr  = AW'(addr);
        cfg_data  = d;
    endtask

    // Drains one burst whose start was already presented.
    task automatic collect(input string tag, input int base, input int len,
                           input int rmode, output int first_v, output int last_c);
        int errs = 0;
        int lerrs = 0;
        int serrs = 0;
        int beats = 0;
        bit held = 1'b0;
        bit fin = 1'b0;
        logic [NB*DW-1:0] hd = '0;
        logic hl = 1'b0;
        first_v = -1;
        last_c = -1;
        for (int c = 0; c < len * 4 + 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            cfg_wr_en = 1'b0;
            coef_ready = (rmode == 0) ? 1'b1 : ((c % 3) == 0);
            if (coef_valid) begin
                if (first_v < 0) first_v = c;
                if (held && (coef_data !== hd || coef_last !== hl)) serrs++;
                if (coef_ready) begin
                    if (coef_data !== expv((base + beats) % 1024)) errs++;
                    if (coef_last !== (beats == len - 1)) lerrs++;
                    beats++;
                    held = 1'b0;
                    if (coef_last) begin
                        fin = 1'b1;
                        last_c = c;
                        break;
                    end
                end else begin
                    held = 1'b1;
                    hd = coef_data;
                    hl = coef_last;
                end
            end
        end
        chk({tag, "_fin"}, 64'(fin), 64'd1);
        chk({tag, "_data_errs"}, 64'(errs), 64'd0);
        chk({tag, "_last_errs"}, 64'(lerrs), 64'd0);
        chk({tag, "_stall_errs"}, 64'(serrs), 64'd0);
        chk({tag, "_beats"}, 64'(beats), 64'(len));
        @(negedge clk);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
        chk({tag, "_valid_off"}, 64'(coef_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic burst(input string tag, input int base, input int len,
                         input int rmode, output int fv, output int lc);
        @(negedge clk);
        start = 1'b1;
        base_addr = AW'(base);
        burst_len = (AW+1)'(len);
        collect(tag, base, len, rmode, fv, lc);
    endtask

    initial begin
        int fv;
        int lc;
        int acc;
        int vseen;

        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(coef_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_drop", 64'(cfg_drop), 64'd0);
        chk("rst_last", 64'(coef_last), 64'd0);
        chk("rst_data", 64'(coef_data), 64'd0);
        rst_n = 1'b1;

        for (int a = 0; a < 1024; a++) begin
            wr(0, a, DW'(a));
            model[0][a] = DW'(a);
            wr(1, a, DW'(17'h1FFFF - a));
            model[1][a] = DW'(17'h1FFFF - a);
        end
        @(negedge clk);
        cfg_wr_en = 1'b0;
        chk("load_nodrop", 64'(cfg_drop), 64'd0);

        burst("t1", 0, 1024, 0, fv, lc);
        chk("t1_latency", 64'(fv), 64'd1);
        chk("t1_rate", 64'(lc), 64'd1024);

        burst("t2", 1020, 8, 0, fv, lc);
        chk("t2_rate", 64'(lc), 64'd8);

        burst("t3", 100, 5, 1, fv, lc);

        @(negedge clk);
        start = 1'b1;
        base_addr = AW'(40);
        burst_len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        vseen = int'(coef_valid);
        @(negedge clk);
        chk("t4_done_pulse", 64'(done), 64'd0);
        for (int i = 0; i < 4; i++) begin
            vseen += int'(coef_valid) + int'(busy);
            @(negedge clk);
        end
        chk("t4_quiet", 64'(vseen), 64'd0);

        @(negedge clk);
        coef_ready = 1'b0;
        start = 1'b1;
        base_addr = AW'(200);
        burst_len = (AW+1)'(16);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd1);
        chk("t5_held_valid", 64'(coef_valid), 64'd1);
        cfg_wr_en = 1'b1;
        cfg_bank = 3'd0;
        cfg_addr = AW'(200);
        cfg_data = 17'h0AAAA;
        start = 1'b1;
        base_addr = AW'(0);
        burst_len = (AW+1)'(3);
        @(negedge clk);
        cfg_wr_en = 1'b0;
        start = 1'b0;
        chk("t5_drop_busy", 64'(cfg_drop), 64'd1);
        @(negedge clk);
        chk("t5_drop_pulse", 64'(cfg_drop), 64'd0);
        collect("t5", 200, 16, 0, fv, lc);

        wr(7, 5, 17'h12345);
        @(negedge clk);
        cfg_wr_en = 1'b0;
        chk("t5_drop_bank", 64'(cfg_drop), 64'd1);

        @(negedge clk);
        cfg_wr_en = 1'b1;
        cfg_bank = 3'd1;
        cfg_addr = AW'(7);
        cfg_data = 17'h00F0F;
        model[1][7] = 17'h00F0F;
        start = 1'b1;
        base_addr = AW'(7);
        burst_len = (AW+1)'(2);
        collect("t5_fwd", 7, 2, 0, fv, lc);
        burst("t5_rb", 0, 12, 0, fv, lc);

        @(negedge clk);
        coef_ready = 1'b1;
        start = 1'b1;
        base_addr = AW'(500);
        burst_len = (AW+1)'(16);
        acc = 0;
        for (int c = 0; c < 40 && acc < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (coef_valid && coef_ready) acc++;
        end
        chk("t6_pre_beats", 64'(acc), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(coef_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_data", 64'(coef_data), 64'd0);
        chk("t6_rst_last", 64'(coef_last), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_no_done", 64'(done), 64'd0);
        burst("t6", 500, 16, 0, fv, lc);

`ifdef FBANK_PARITY_EN
        chk("par_clean", 64'(par_err), 64'd0);
        dut.g_bank[1].mem[9][0] = ~dut.g_bank[1].mem[9][0];
        model[1][9][0] = ~model[1][9][0];
        burst("par", 9, 1, 0, fv, lc);
        chk("par_set", 64'(par_err), 64'd1);
        @(negedge clk);
        start = 1'b1;
        burst_len = '0;
        @(negedge clk);
        start = 1'b0;
        chk("par_clear", 64'(par_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
